// File: rtl/muldiv_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_ctrl
// Description : Sequencer between the CPU and external multiply/divide cores,
//               owning the architectural HI/LO registers and MFHI/MFLO reads.
// Revision    : 1.0 - initial release
// ============================================================================
module muldiv_ctrl #(
   parameter int TIMEOUT = 40
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        op_valid,
   input  logic [1:0]  op_code,
   input  logic [31:0] op_a,
   input  logic [31:0] op_b,
   output logic        op_ready,
   output logic        mult_start,
   output logic        div_start,
   output logic [31:0] core_a,
   output logic [31:0] core_b,
   input  logic        mult_done,
   input  logic        div_done,
   input  logic [31:0] mult_hi,
   input  logic [31:0] mult_lo,
   input  logic [31:0] div_hi,
   input  logic [31:0] div_lo,
   output logic [31:0] hi,
   output logic [31:0] lo,
   output logic [31:0] rd_data,
   output logic        rd_valid,
   output logic        op_done,
   output logic        div_zero,
   output logic        timeout_err
);

   localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [CW-1:0] c_CNT_LAST = CW'(TIMEOUT - 1);

   localparam logic [1:0] c_IDLE  = 2'd0;
   localparam logic [1:0] c_START = 2'd1;
   localparam logic [1:0] c_WAIT  = 2'd2;
   localparam logic [1:0] c_DONE  = 2'd3;

   localparam logic [1:0] c_OP_MULT = 2'b00;
   localparam logic [1:0] c_OP_DIV  = 2'b01;
   localparam logic [1:0] c_OP_MFHI = 2'b10;
   localparam logic [1:0] c_OP_MFLO = 2'b11;

   logic [1:0]    r_state;
   logic [1:0]    w_next_state;
   logic          r_sel;
   logic [CW-1:0] r_cnt;
   logic [31:0]   r_core_a;
   logic [31:0]   r_core_b;
   logic [31:0]   r_hi;
   logic [31:0]   r_lo;
   logic [31:0]   r_rd_data;
   logic          r_rd_valid;
   logic          r_div_zero;
   logic          r_timeout;

   logic w_accept;
   logic w_launch;
   logic w_div_by_zero;
   logic w_sel_done;
   logic w_timeout;

   assign w_accept      = op_valid && (r_state == c_IDLE);
   assign w_div_by_zero = w_accept && (op_code == c_OP_DIV) && (op_b == 32'd0);
   assign w_launch      = w_accept && ((op_code == c_OP_MULT) ||
                                       ((op_code == c_OP_DIV) && (op_b != 32'd0)));
   // Only the core that was started may complete the operation.
   assign w_sel_done    = r_sel ? div_done : mult_done;
   assign w_timeout     = (r_state == c_WAIT) && !w_sel_done && (r_cnt == c_CNT_LAST);

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= c_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   always_comb begin
      w_next_state = r_state;
      case (r_state)
         c_IDLE:  if (w_launch) w_next_state = c_START;
         c_START: w_next_state = c_WAIT;
         c_WAIT: begin
            if (w_sel_done) begin
               w_next_state = c_DONE;
            end else if (r_cnt == c_CNT_LAST) begin
               w_next_state = c_IDLE;
            end
         end
         c_DONE:  w_next_state = c_IDLE;
         default: w_next_state = c_IDLE;
      endcase
   end

   always_comb begin
      op_ready   = 1'b0;
      mult_start = 1'b0;
      div_start  = 1'b0;
      op_done    = 1'b0;
      case (r_state)
         c_IDLE:  op_ready = 1'b1;
         c_START: begin
            mult_start = !r_sel;
            div_start  = r_sel;
         end
         c_DONE:  op_done = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_sel      <= 1'b0;
         r_cnt      <= '0;
         r_core_a   <= 32'd0;
         r_core_b   <= 32'd0;
         r_hi       <= 32'd0;
         r_lo       <= 32'd0;
         r_rd_data  <= 32'd0;
         r_rd_valid <= 1'b0;
         r_div_zero <= 1'b0;
         r_timeout  <= 1'b0;
      end else begin
         r_rd_valid <= 1'b0;
         r_div_zero <= w_div_by_zero;
         r_timeout  <= w_timeout;
         if (w_launch) begin
            r_core_a <= op_a;
            r_core_b <= op_b;
            r_sel    <= op_code[0];
         end
         if (r_state == c_START) begin
            r_cnt <= '0;
         end else if (r_state == c_WAIT) begin
            r_cnt <= r_cnt + CW'(1);
         end
         if ((r_state == c_WAIT) && w_sel_done) begin
            r_hi <= r_sel ? div_hi : mult_hi;
            r_lo <= r_sel ? div_lo : mult_lo;
         end
         if (w_accept && (op_code == c_OP_MFHI)) begin
            r_rd_data  <= r_hi;
            r_rd_valid <= 1'b1;
         end else if (w_accept && (op_code == c_OP_MFLO)) begin
            r_rd_data  <= r_lo;
            r_rd_valid <= 1'b1;
         end
      end
   end

   assign core_a      = r_core_a;
   assign core_b      = r_core_b;
   assign hi          = r_hi;
   assign lo          = r_lo;
   assign rd_data     = r_rd_data;
   assign rd_valid    = r_rd_valid;
   assign div_zero    = r_div_zero;
   assign timeout_err = r_timeout;

endmodule
`default_nettype wire

// File: tb/tb_muldiv_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_muldiv_ctrl
// Description : Directed, table-driven bench for muldiv_ctrl with stub cores.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_muldiv_ctrl;

   localparam logic [1:0] c_MULT = 2'b00;
   localparam logic [1:0] c_DIV  = 2'b01;
   localparam logic [1:0] c_MFHI = 2'b10;
   localparam logic [1:0] c_MFLO = 2'b11;

   logic        clk;
   logic        reset;
   logic        op_valid;
   logic [1:0]  op_code;
   logic [31:0] op_a, op_b;
   logic        op_ready, mult_start, div_start;
   logic [31:0] core_a, core_b;
   logic        mult_done, div_done;
   logic [31:0] mult_hi, mult_lo, div_hi, div_lo;
   logic [31:0] hi, lo, rd_data;
   logic        rd_valid, op_done, div_zero, timeout_err;

   muldiv_ctrl #(.TIMEOUT(40)) dut (
      .clk(clk), .reset(reset),
      .op_valid(op_valid), .op_code(op_code), .op_a(op_a), .op_b(op_b),
      .op_ready(op_ready), .mult_start(mult_start), .div_start(div_start),
      .core_a(core_a), .core_b(core_b),
      .mult_done(mult_done), .div_done(div_done),
      .mult_hi(mult_hi), .mult_lo(mult_lo), .div_hi(div_hi), .div_lo(div_lo),
      .hi(hi), .lo(lo), .rd_data(rd_data), .rd_valid(rd_valid),
      .op_done(op_done), .div_zero(div_zero), .timeout_err(timeout_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int cnt_ms = 0, cnt_ds = 0, cnt_done = 0, cnt_dz = 0, cnt_to = 0, cnt_rv = 0;
   always @(negedge clk) begin
      if (mult_start)  cnt_ms   <= cnt_ms + 1;
      if (div_start)   cnt_ds   <= cnt_ds + 1;
      if (op_done)     cnt_done <= cnt_done + 1;
      if (div_zero)    cnt_dz   <= cnt_dz + 1;
      if (timeout_err) cnt_to   <= cnt_to + 1;
      if (rd_valid)    cnt_rv   <= cnt_rv + 1;
   end

   typedef struct {
      logic [1:0]  code;
      logic [31:0] a, b;
      logic [31:0] rhi, rlo;   // selected core results
      int          lat;        // WAIT cycles before done; -1 never
      bit          spur;       // hold the other core's done high
      int          ecyc, ems, eds, edone, edz, eto, erv;
      logic [31:0] ehi, elo, erd;
   } vec_t;

   vec_t vecs[9];
   int   n_pass = 0;
   int   n_total = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Holds op_valid until a cycle with op_ready, returns just after the accepting edge.
   task automatic accept();
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < 200 && !ok; i++) begin
         if (op_ready) ok = 1'b1;
         tick();
      end
      check("accept_bound", 32'(ok), 32'd1);
   endtask

   task automatic run_op(input vec_t v, input int idx, output int cyc);
      bit fin;
      bit is_div;
      cyc = 0;
      is_div = (v.code == c_DIV);
      if (v.code == c_MULT) begin
         mult_hi = v.rhi; mult_lo = v.rlo; div_hi = ~v.rhi; div_lo = ~v.rlo;
      end else if (is_div) begin
         div_hi = v.rhi; div_lo = v.rlo; mult_hi = ~v.rhi; mult_lo = ~v.rlo;
      end
      op_valid = 1'b1; op_code = v.code; op_a = v.a; op_b = v.b;
      accept();
      op_valid = 1'b0;
      if ((v.code == c_MULT) || (is_div && v.b != 32'd0)) begin
         check($sformatf("row%0d_core_a", idx), core_a, v.a);
         check($sformatf("row%0d_core_b", idx), core_b, v.b);
         tick();
         fin = 1'b0;
         for (int k = 0; k < 100 && !fin; k++) begin
            if (is_div) begin
               div_done = (k == v.lat); mult_done = v.spur;
            end else begin
               mult_done = (k == v.lat); div_done = v.spur;
            end
            tick();
            mult_done = 1'b0; div_done = 1'b0;
            if (op_ready) begin
               fin = 1'b1;
               cyc = k + 1;
            end
         end
         check($sformatf("row%0d_cycles", idx), 32'(cyc), 32'(v.ecyc));
      end else begin
         if (is_div) check($sformatf("row%0d_ready_kept", idx), 32'(op_ready), 32'd1);
         tick();
      end
      tick();
   endtask

   int m0, d0, dn0, dz0, to0, rv0, cyc;

   initial begin
      vecs[0] = '{c_MULT, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 33, 1'b1,
                  35, 1, 0, 1, 0, 0, 0, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 32'd0};
      vecs[1] = '{c_DIV, 32'd100, 32'd7, 32'd2, 32'd14, 5, 1'b1,
                  7, 0, 1, 1, 0, 0, 0, 32'd2, 32'd14, 32'd0};
      vecs[2] = '{c_MFLO, 32'd0, 32'd0, 32'd0, 32'd0, 0, 1'b0,
                  0, 0, 0, 0, 0, 0, 1, 32'd2, 32'd14, 32'd14};
      vecs[3] = '{c_MFHI, 32'd0, 32'd0, 32'd0, 32'd0, 0, 1'b0,
                  0, 0, 0, 0, 0, 0, 1, 32'd2, 32'd14, 32'd2};
      vecs[4] = '{c_MULT, 32'd3, 32'd4, 32'd5, 32'd9, 39, 1'b0,
                  41, 1, 0, 1, 0, 0, 0, 32'd5, 32'd9, 32'd2};
      vecs[5] = '{c_DIV, 32'd123, 32'd0, 32'd0, 32'd0, 0, 1'b0,
                  0, 0, 0, 0, 1, 0, 0, 32'd5, 32'd9, 32'd2};
      vecs[6] = '{c_MULT, 32'd2, 32'd3, 32'h1111_1111, 32'h2222_2222, -1, 1'b1,
                  40, 1, 0, 0, 0, 1, 0, 32'd5, 32'd9, 32'd2};
      vecs[7] = '{c_DIV, 32'd7, 32'd2, 32'd1, 32'd3, 0, 1'b1,
                  2, 0, 1, 1, 0, 0, 0, 32'd1, 32'd3, 32'd2};
      vecs[8] = '{c_MFHI, 32'd0, 32'd0, 32'd0, 32'd0, 0, 1'b0,
                  0, 0, 0, 0, 0, 0, 1, 32'd1, 32'd3, 32'd1};

      reset = 1'b1; op_valid = 1'b0; op_code = 2'b00; op_a = '0; op_b = '0;
      mult_done = 1'b0; div_done = 1'b0;
      mult_hi = '0; mult_lo = '0; div_hi = '0; div_lo = '0;
      repeat (3) tick();
      reset = 1'b0;
      check("rst_hi", hi, 32'd0);
      check("rst_lo", lo, 32'd0);
      check("rst_rd_data", rd_data, 32'd0);
      check("rst_core_a", core_a, 32'd0);
      check("rst_op_ready", 32'(op_ready), 32'd1);
      check("rst_pulses", 32'({mult_start, div_start, op_done, div_zero, timeout_err, rd_valid}), 32'd0);

      for (int i = 0; i < 9; i++) begin
         m0 = cnt_ms; d0 = cnt_ds; dn0 = cnt_done; dz0 = cnt_dz; to0 = cnt_to; rv0 = cnt_rv;
         run_op(vecs[i], i, cyc);
         check($sformatf("row%0d_mult_start", i), 32'(cnt_ms - m0), 32'(vecs[i].ems));
         check($sformatf("row%0d_div_start", i), 32'(cnt_ds - d0), 32'(vecs[i].eds));
         check($sformatf("row%0d_op_done", i), 32'(cnt_done - dn0), 32'(vecs[i].edone));
         check($sformatf("row%0d_div_zero", i), 32'(cnt_dz - dz0), 32'(vecs[i].edz));
         check($sformatf("row%0d_timeout", i), 32'(cnt_to - to0), 32'(vecs[i].eto));
         check($sformatf("row%0d_rd_valid", i), 32'(cnt_rv - rv0), 32'(vecs[i].erv));
         check($sformatf("row%0d_hi", i), hi, vecs[i].ehi);
         check($sformatf("row%0d_lo", i), lo, vecs[i].elo);
         check($sformatf("row%0d_rd_data", i), rd_data, vecs[i].erd);
      end

      // Request held through a busy MULT, spurious div_done meanwhile.
      mult_hi = 32'd0; mult_lo = 32'd12; div_hi = 32'hDEAD_0000; div_lo = 32'h0000_BEEF;
      op_code = c_MULT; op_a = 32'd3; op_b = 32'd4; op_valid = 1'b1;
      accept();
      op_code = c_MFLO;
      rv0 = cnt_rv;
      div_done = 1'b1;
      repeat (3) tick();
      check("busy_ready_low", 32'(op_ready), 32'd0);
      mult_done = 1'b1;
      tick();
      mult_done = 1'b0; div_done = 1'b0;
      check("busy_op_done", 32'(op_done), 32'd1);
      tick();
      check("busy_ready_back", 32'(op_ready), 32'd1);
      check("busy_not_accepted", 32'(cnt_rv - rv0), 32'd0);
      tick();
      op_valid = 1'b0;
      check("busy_rd_valid", 32'(rd_valid), 32'd1);
      check("busy_rd_data", rd_data, 32'd12);
      tick();
      check("busy_hi", hi, 32'd0);
      check("busy_lo", lo, 32'd12);

      // Reset during WAIT, late mult_done afterwards.
      mult_hi = 32'hAAAA_AAAA; mult_lo = 32'h5555_5555;
      op_code = c_MULT; op_a = 32'd9; op_b = 32'd9; op_valid = 1'b1;
      accept();
      op_valid = 1'b0;
      repeat (2) tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      dn0 = cnt_done; m0 = cnt_ms;
      mult_done = 1'b1;
      repeat (2) tick();
      mult_done = 1'b0;
      tick();
      check("rstw_hi", hi, 32'd0);
      check("rstw_lo", lo, 32'd0);
      check("rstw_core_a", core_a, 32'd0);
      check("rstw_core_b", core_b, 32'd0);
      check("rstw_rd_data", rd_data, 32'd0);
      check("rstw_op_ready", 32'(op_ready), 32'd1);
      check("rstw_no_done", 32'(cnt_done - dn0), 32'd0);
      check("rstw_no_start", 32'(cnt_ms - m0), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/muldiv_ctrl.md
MULDIV_CTRL -- requirements
Module: muldiv_ctrl

Interface
REQ-001 Parameter TIMEOUT, default 40, SHALL set the maximum WAIT-state cycles before abort.
REQ-002 clk  input  1  clock; all logic on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 op_valid  input  1  CPU request strobe.
REQ-005 op_code  input  2  00 MULT, 01 DIV, 10 MFHI, 11 MFLO.
REQ-006 op_a, op_b  input  32 each  operands; op_b is the divisor for DIV.
REQ-007 op_ready  output  1  high only in IDLE; request accepted when op_valid & op_ready.
REQ-008 mult_start, div_start  output  1 each  one-cycle start pulses to the cores.
REQ-009 core_a, core_b  output  32 each  latched operands, stable from start until return to IDLE.
REQ-010 mult_done, div_done  input  1 each  core completion flags.
REQ-011 mult_hi, mult_lo, div_hi, div_lo  input  32 each  core results (div_hi remainder, div_lo quotient).
REQ-012 hi, lo  output  32 each  architectural HI/LO registers.
REQ-013 rd_data  output  32, rd_valid  output  1  MFHI/MFLO read return.
REQ-014 op_done, div_zero, timeout_err  output  1 each  one-cycle status pulses.

Function
REQ-015 States SHALL be IDLE, START, WAIT, DONE; a 1-bit sel register SHALL record MULT (0) or DIV (1).
REQ-016 In IDLE, accepted MULT or DIV with nonzero op_b SHALL latch op_a/op_b into core_a/core_b, set sel, go to START.
REQ-017 START SHALL last exactly one cycle, asserting mult_start (sel=0) or div_start (sel=1), then go to WAIT with the wait counter cleared.
REQ-018 In WAIT the counter SHALL increment each cycle; only the selected core's done flag SHALL be honoured.
REQ-019 Selected done sampled high at edge N SHALL load hi/lo from that core's results at edge N, enter DONE, and pulse op_done during cycle N+1.
REQ-020 DONE SHALL last one cycle, then IDLE; op_ready high from cycle N+2.
REQ-021 Counter reaching TIMEOUT-1 without done SHALL pulse timeout_err for one cycle, leave hi/lo unchanged, return to IDLE.
REQ-022 Done and timeout in the same cycle: done SHALL win; no timeout_err.
REQ-023 Accepted DIV with op_b == 0 SHALL issue no div_start, leave hi/lo unchanged, pulse div_zero in the next cycle, remain in IDLE.
REQ-024 Accepted MFHI/MFLO SHALL drive rd_data = hi/lo with rd_valid high for one cycle on the next cycle; state stays IDLE.
REQ-025 MFHI/MFLO accepted the cycle after DONE SHALL return the newly written value.
REQ-026 op_valid while op_ready is low SHALL be ignored; requester holds until accepted.
REQ-027 mult_done/div_done in IDLE, START, DONE, or for the unselected core SHALL be ignored.
REQ-028 rd_data SHALL hold its last value when rd_valid is low.
REQ-029 Start pulses SHALL never be asserted outside START; at most one per accepted operation.

Reset
REQ-030 reset SHALL force IDLE, sel=0, counter=0, hi=lo=rd_data=core_a=core_b=0, all start and status pulses low, op_ready high next cycle.
REQ-031 reset during START or WAIT SHALL abort without updating hi/lo; later core done SHALL be ignored.

Verification
REQ-032 MULT a=7, b=-3; mult_done after 33 cycles with {hi,lo}={FFFFFFFF,FFFFFFEB} -> single mult_start, hi=FFFFFFFF, lo=FFFFFFEB, one op_done.
REQ-033 DIV a=100, b=7, div_done hi=2 lo=14 -> div_start once, hi=2, lo=14; then MFLO -> rd_data=14, rd_valid one cycle.
REQ-034 DIV b=0 with hi=5, lo=9 -> no div_start, div_zero one cycle, hi=5, lo=9, op_ready stays high.
REQ-035 MULT with mult_done never asserted, TIMEOUT=40 -> timeout_err exactly 40 cycles after WAIT entry, hi/lo unchanged, IDLE.
REQ-036 op_valid held during WAIT plus spurious div_done while sel=0 -> not accepted until op_ready; hi/lo untouched by div results.
REQ-037 reset asserted in WAIT, then mult_done -> all outputs reset values, hi=lo=0, no op_done.
